fetch_pc_unit: RTL and testbench

Instruction-fetch front end of the pipelined datapath, directly upstream of the hazard unit and the IF/ID latch. Holds the architectural PC, drives the instruction-cache request, and computes the next PC from the redirect sources (jump, jump-register, taken branch). Advances only when the hazard unit's `pc_en` and the cache's `ihit` allow it. Also captures redirects that arrive while a fetch is stalled, so that no control transfer is lost.

---
 rtl/fetch_pc_unit.sv | 136 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module      : fetch_pc_unit
// Description : Instruction-fetch PC register, next-PC selection and capture
//               of redirects that arrive while a fetch is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pc_en,
    input  logic [1:0]  pc_src,
    input  logic        branch_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic        ihit,
    input  logic        halt,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] npc,
    output logic        fetch_valid,
    output logic        halted
);

    localparam logic [1:0] c_SRC_NEXT   = 2'd0;
    localparam logic [1:0] c_SRC_BRANCH = 2'd1;
    localparam logic [1:0] c_SRC_JUMP   = 2'd2;
    localparam logic [1:0] c_SRC_JR     = 2'd3;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_pend_v;
    logic [31:0] r_pend_tgt;

    logic        w_redir;
    logic [31:0] w_live_tgt;
    logic        w_advance;
    logic [31:0] w_pc_plus4;

    // Word-aligned targets: low two bits are always dropped.
    always_comb begin
        w_live_tgt = 32'h0;
        w_redir    = 1'b0;
        case (pc_src)
            c_SRC_BRANCH: begin
                w_live_tgt = {branch_target[31:2], 2'b00};
                w_redir    = branch_sel;
            end
            c_SRC_JUMP: begin
                w_live_tgt = {jump_target[31:2], 2'b00};
                w_redir    = 1'b1;
            end
            c_SRC_JR: begin
                w_live_tgt = {jr_target[31:2], 2'b00};
                w_redir    = 1'b1;
            end
            c_SRC_NEXT: begin
                w_live_tgt = 32'h0;
                w_redir    = 1'b0;
            end
            default: begin
                w_live_tgt = 32'h0;
                w_redir    = 1'b0;
            end
        endcase
    end

    assign w_advance  = ihit & pc_en & (r_state == FETCH);
    assign w_pc_plus4 = r_pc + 32'd4;

    assign iaddr       = r_pc;
    assign npc         = w_pc_plus4;
    assign iREN        = (r_state == FETCH);
    assign halted      = (r_state == HALT);
    // A hit on a redirect cycle is wrong-path; IF/ID is flushed alongside.
    assign fetch_valid = w_advance & ~w_redir & ~r_pend_v & ~halt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= BOOT;
            r_pc       <= PC_INIT;
            r_pend_v   <= 1'b0;
            r_pend_tgt <= 32'h0;
        end else begin
            case (r_state)
                BOOT: begin
                    if (halt) begin
                        r_state  <= HALT;
                        r_pend_v <= 1'b0;
                    end else begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (halt) begin
                        r_state  <= HALT;
                        r_pend_v <= 1'b0;
                    end else if (w_advance) begin
                        if (w_redir) begin
                            r_pc     <= w_live_tgt;
                            r_pend_v <= 1'b0;
                        end else if (r_pend_v) begin
                            r_pc     <= r_pend_tgt;
                            r_pend_v <= 1'b0;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end else if (w_redir) begin
                        // Newest redirect wins while the fetch is stalled.
                        r_pend_tgt <= w_live_tgt;
                        r_pend_v   <= 1'b1;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Directed self-checking bench for fetch_pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

    logic        CLK;
    logic        nRST;
    logic        pc_en;
    logic [1:0]  pc_src;
    logic        branch_sel;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic        ihit;
    logic        halt;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] npc;
    logic        fetch_valid;
    logic        halted;

    int checks;
    int failures;

    localparam logic [1:0] c_NEXT   = 2'd0;
    localparam logic [1:0] c_BRANCH = 2'd1;
    localparam logic [1:0] c_JUMP   = 2'd2;
    localparam logic [1:0] c_JR     = 2'd3;

    fetch_pc_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pc_en        (pc_en),
        .pc_src       (pc_src),
        .branch_sel   (branch_sel),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .jr_target    (jr_target),
        .ihit         (ihit),
        .halt         (halt),
        .iREN         (iREN),
        .iaddr        (iaddr),
        .npc          (npc),
        .fetch_valid  (fetch_valid),
        .halted       (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic h, input logic e, input logic [1:0] s);
        ihit   = h;
        pc_en  = e;
        pc_src = s;
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        halt = 1'b0; branch_sel = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
        nRST = 1'b0;
        drive(1'b1, 1'b1, c_NEXT);
        checks++; if (iaddr !== 32'h0) begin failures++; $display("FAIL rst_iaddr got %h exp %h", iaddr, 32'h0); end
        checks++; if (npc !== 32'h4) begin failures++; $display("FAIL rst_npc got %h exp %h", npc, 32'h4); end
        checks++; if (iREN !== 1'b0) begin failures++; $display("FAIL rst_iREN got %b exp 0", iREN); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got %b exp 0", halted); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_fv got %b exp 0", fetch_valid); end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        checks++; if (iREN !== 1'b0 || iaddr !== 32'h0 || fetch_valid !== 1'b0) begin failures++; $display("FAIL boot iREN=%b iaddr=%h fv=%b exp 0/0/0", iREN, iaddr, fetch_valid); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            checks++;
            if (iREN !== 1'b1 || iaddr !== 32'(i * 4) || fetch_valid !== 1'b1) begin
                failures++;
                $display("FAIL seq%0d iREN=%b iaddr=%h fv=%b exp 1/%h/1", i, iREN, iaddr, fetch_valid, 32'(i * 4));
            end
        end
        cyc(); #1;
        checks++; if (iaddr !== 32'h10) begin failures++; $display("FAIL seq_end iaddr got %h exp %h", iaddr, 32'h10); end
    endtask

    task automatic test_jump_branch();
        jump_target = 32'h400;
        drive(1'b1, 1'b1, c_JUMP);
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL jump_fv got %b exp 0", fetch_valid); end
        cyc(); #1;
        checks++; if (iaddr !== 32'h400 || npc !== 32'h404) begin failures++; $display("FAIL jump_tgt iaddr=%h npc=%h exp 400/404", iaddr, npc); end
        jump_target = 32'h10;
        drive(1'b1, 1'b1, c_JUMP);
        cyc(); #1;
        branch_target = 32'h999; branch_sel = 1'b0;
        drive(1'b1, 1'b1, c_BRANCH);
        checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL bnt_fv got %b exp 1", fetch_valid); end
        cyc(); #1;
        checks++; if (iaddr !== 32'h14) begin failures++; $display("FAIL bnt_iaddr got %h exp %h", iaddr, 32'h14); end
    endtask

    task automatic test_miss_pending();
        jr_target = 32'h203;
        drive(1'b0, 1'b1, c_JR);
        checks++; if (fetch_valid !== 1'b0 || iaddr !== 32'h14) begin failures++; $display("FAIL miss_jr fv=%b iaddr=%h exp 0/14", fetch_valid, iaddr); end
        cyc();
        drive(1'b0, 1'b1, c_NEXT);
        for (int i = 0; i < 2; i++) begin
            checks++; if (iaddr !== 32'h14 || iREN !== 1'b1) begin failures++; $display("FAIL miss_hold%0d iaddr=%h iREN=%b exp 14/1", i, iaddr, iREN); end
            cyc(); #1;
        end
        drive(1'b1, 1'b1, c_NEXT);
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL pend_hit_fv got %b exp 0", fetch_valid); end
        cyc(); #1;
        checks++; if (iaddr !== 32'h200) begin failures++; $display("FAIL pend_tgt got %h exp %h", iaddr, 32'h200); end
    endtask

    task automatic test_pend_vs_live();
        jump_target = 32'h100;
        drive(1'b0, 1'b1, c_JUMP);
        cyc();
        branch_target = 32'h300; branch_sel = 1'b1;
        drive(1'b1, 1'b1, c_BRANCH);
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL live_fv got %b exp 0", fetch_valid); end
        cyc(); #1;
        checks++; if (iaddr !== 32'h300) begin failures++; $display("FAIL live_wins got %h exp %h", iaddr, 32'h300); end
        branch_sel = 1'b0;
        drive(1'b1, 1'b1, c_NEXT);
        checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL pend_clr_fv got %b exp 1", fetch_valid); end
        cyc(); #1;
        checks++; if (iaddr !== 32'h304) begin failures++; $display("FAIL pend_clr_iaddr got %h exp %h", iaddr, 32'h304); end
    endtask

    task automatic test_stall();
        jump_target = 32'h20;
        drive(1'b1, 1'b1, c_JUMP);
        cyc();
        drive(1'b1, 1'b0, c_NEXT);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (iaddr !== 32'h20 || fetch_valid !== 1'b0 || iREN !== 1'b1) begin
                failures++;
                $display("FAIL stall%0d iaddr=%h fv=%b iREN=%b exp 20/0/1", i, iaddr, fetch_valid, iREN);
            end
            cyc(); #1;
        end
        drive(1'b1, 1'b1, c_NEXT);
        checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL stall_rel_fv got %b exp 1", fetch_valid); end
        cyc(); #1;
        checks++; if (iaddr !== 32'h24) begin failures++; $display("FAIL stall_rel_iaddr got %h exp %h", iaddr, 32'h24); end
    endtask

    task automatic test_halt();
        halt = 1'b1;
        drive(1'b1, 1'b1, c_NEXT);
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL halt_fv got %b exp 0", fetch_valid); end
        cyc();
        halt = 1'b0;
        jump_target = 32'h500;
        drive(1'b1, 1'b1, c_JUMP);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (iREN !== 1'b0 || halted !== 1'b1 || iaddr !== 32'h24 || fetch_valid !== 1'b0) begin
                failures++;
                $display("FAIL halted%0d iREN=%b halted=%b iaddr=%h fv=%b exp 0/1/24/0", i, iREN, halted, iaddr, fetch_valid);
            end
            cyc(); #1;
        end
        drive(1'b1, 1'b1, c_NEXT);
        do_reset();
        checks++; if (iaddr !== 32'h0 || iREN !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL halt_rst iaddr=%h iREN=%b halted=%b exp 0/0/0", iaddr, iREN, halted); end
        cyc(); #1;
        checks++; if (iREN !== 1'b1 || fetch_valid !== 1'b1) begin failures++; $display("FAIL halt_rst_fetch iREN=%b fv=%b exp 1/1", iREN, fetch_valid); end
    endtask

    task automatic test_reset_mid_stall();
        cyc();
        jump_target = 32'h700;
        drive(1'b0, 1'b1, c_JUMP);
        cyc();
        drive(1'b1, 1'b1, c_NEXT);
        do_reset();
        cyc(); #1;
        checks++; if (fetch_valid !== 1'b1 || iaddr !== 32'h0) begin failures++; $display("FAIL rst_pend_lost fv=%b iaddr=%h exp 1/0", fetch_valid, iaddr); end
        cyc(); #1;
        checks++; if (iaddr !== 32'h4) begin failures++; $display("FAIL rst_pend_next got %h exp %h", iaddr, 32'h4); end
    endtask

    task automatic test_wrap();
        jump_target = 32'hFFFF_FFFE;
        drive(1'b1, 1'b1, c_JUMP);
        cyc(); #1;
        checks++; if (iaddr !== 32'hFFFF_FFFC || npc !== 32'h0) begin failures++; $display("FAIL wrap_top iaddr=%h npc=%h exp fffffffc/0", iaddr, npc); end
        drive(1'b1, 1'b1, c_NEXT);
        cyc(); #1;
        checks++; if (iaddr !== 32'h0 || npc !== 32'h4) begin failures++; $display("FAIL wrap iaddr=%h npc=%h exp 0/4", iaddr, npc); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nRST     = 1'b0;
        ihit     = 1'b0;
        pc_en    = 1'b0;
        pc_src   = c_NEXT;
        @(negedge CLK);
        test_reset();
        test_sequential();
        test_jump_branch();
        test_miss_pending();
        test_pend_vs_live();
        test_stall();
        test_halt();
        test_reset_mid_stall();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
